// File: rtl/cmd_initiator.sv
// Command initiator: queues RD/WR/ADD/SUB requests in a small FIFO and issues them one
// per cycle to a storage module. A read stalls further issue until its response is taken.
module cmd_initiator #(
  parameter int unsigned mem_width  = 16,
  parameter int unsigned mem_length = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [mem_length-1:0] req_addA,
  input  logic [mem_length-1:0] req_addB,
  input  logic [mem_length-1:0] req_addC,
  input  logic [mem_width-1:0]  req_data,
  output logic [1:0]            cmd,
  output logic [mem_length-1:0] addA,
  output logic [mem_length-1:0] addB,
  output logic [mem_length-1:0] addC,
  output logic [mem_width-1:0]  DQ_i,
  input  logic [mem_width-1:0]  DQ_o,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [mem_width-1:0]  rsp_data,
  output logic [15:0]           issued_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [1:0]  CmdRd = 2'd0;

  typedef struct packed {
    logic [1:0]            cmd;
    logic [mem_length-1:0] a;
    logic [mem_length-1:0] b;
    logic [mem_length-1:0] c;
    logic [mem_width-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StRsp} state_e;

  entry_t               fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push, pop, fifo_empty;
  state_e               state_q, state_d;
  entry_t               out_q, out_d;
  logic [2:0]           lat_q, lat_d;
  logic [mem_width-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]          issued_q, issued_d;

  // Full blocks pushes even if a pop happens in the same cycle.
  assign req_ready  = (count_q != CntW'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign fifo_empty = (count_q == '0);

  // FIFO entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= '{cmd: req_cmd, a: req_addA, b: req_addB, c: req_addC, data: req_data};
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM: pops the head into the output register, which otherwise holds the idle pattern.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    out_d      = '0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (out_q.cmd == CmdRd) begin
          state_d = StWaitRd;
          lat_d   = 3'd1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitRd: begin
        // lat_q is the number of cycles elapsed since the read issue cycle.
        if (lat_q == 3'(RD_LAT)) begin
          rsp_data_d = DQ_o;
          state_d    = StRsp;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) out_d = fifo_q[rptr_q];
  end

  // Every cycle spent in issue is exactly one command handed to storage.
  always_comb begin
    issued_d = (state_q == StIssue) ? issued_q + 16'd1 : issued_q;
  end

  // State registers; reset drops queued commands and any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      lat_q      <= '0;
      rsp_data_q <= '0;
      issued_q   <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      lat_q      <= lat_d;
      rsp_data_q <= rsp_data_d;
      issued_q   <= issued_d;
    end
  end

  assign cmd        = out_q.cmd;
  assign addA       = out_q.a;
  assign addB       = out_q.b;
  assign addC       = out_q.c;
  assign DQ_i       = out_q.data;
  assign rsp_valid  = (state_q == StRsp);
  assign rsp_data   = rsp_data_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_cmd_initiator.sv
// Bench for cmd_initiator: a storage model answers the command bus, a reference model
// derives expected issue order and read data from the request stream.
module tb_cmd_initiator;

  localparam int unsigned W = 16, L = 8, D = 4, LAT = 1;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, ADD = 2'd2, SUB = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1;
  logic [1:0] req_cmd = '0, cmd;
  logic [L-1:0] req_addA = '0, req_addB = '0, req_addC = '0, addA, addB, addC;
  logic [W-1:0] req_data = '0, DQ_i, DQ_o, rsp_data;
  logic [15:0] issued_cnt;

  cmd_initiator #(.mem_width(W), .mem_length(L), .FIFO_DEPTH(D), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addA(req_addA), .req_addB(req_addB), .req_addC(req_addC), .req_data(req_data),
    .cmd(cmd), .addA(addA), .addB(addB), .addC(addC), .DQ_i(DQ_i), .DQ_o(DQ_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, pushed = 0, rsp_hi = 0;
  longint cyc = 0;
  logic rnd_ready = 1'b0;

  // Storage model state and reference model state.
  logic [W-1:0] mem [256];
  logic [W-1:0] pipe [LAT];
  logic [1:0] s_cmd;
  logic [L-1:0] s_a, s_b, s_c;
  logic [W-1:0] s_d;
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] expq [$];
  logic [41:0] exp_iss [$];
  longint iss_cyc [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Storage: bus sampled mid-cycle, committed at the following rising edge.
  always @(negedge clk) begin
    s_cmd <= cmd; s_a <= addA; s_b <= addB; s_c <= addC; s_d <= DQ_i;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (s_cmd)
      WR:      mem[s_a] <= s_d;
      ADD:     mem[s_c] <= mem[s_a] + mem[s_b];
      SUB:     mem[s_c] <= mem[s_a] - mem[s_b];
      default: ;
    endcase
    pipe[0] <= mem[s_a];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign DQ_o = pipe[LAT-1];

  // Monitor: an issued_cnt step marks the previous cycle's bus as an issued command.
  initial begin : mon
    logic [15:0] prev_cnt;
    logic [41:0] prev_bus, e, o;
    logic [W-1:0] er;
    prev_cnt = '0;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (issued_cnt == prev_cnt + 16'd1) begin
          iss_cyc.push_back(cyc);
          if (exp_iss.size() == 0) begin
            chk("issue_unexpected", 64'(exp_iss.size()), 64'd1);
          end else begin
            e = exp_iss.pop_front();
            o = prev_bus;
            if (e[41:40] != WR) begin e[15:0] = '0; o[15:0] = '0; end
            chk("issue_order", 64'(o), 64'(e));
          end
        end
        if (rsp_valid) rsp_hi++;
        if (rsp_valid && rsp_ready) begin
          if (expq.size() == 0) begin
            chk("rsp_unexpected", 64'(expq.size()), 64'd1);
          end else begin
            er = expq.pop_front();
            chk("rsp_data", 64'(rsp_data), 64'(er));
          end
        end
      end
      prev_cnt = issued_cnt;
      prev_bus = {cmd, addA, addB, addC, DQ_i};
    end
  end

  function automatic void model_push(input logic [1:0] c, input logic [L-1:0] a, b, cc,
                                     input logic [W-1:0] d);
    exp_iss.push_back({c, a, b, cc, d});
    case (c)
      RD:      expq.push_back(ref_mem[a]);
      WR:      ref_mem[a] = d;
      ADD:     ref_mem[cc] = ref_mem[a] + ref_mem[b];
      default: ref_mem[cc] = ref_mem[a] - ref_mem[b];
    endcase
    pushed++;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [1:0] c, input logic [L-1:0] a, b, cc, input logic [W-1:0] d);
    int n;
    logic ok;
    req_valid = 1'b1; req_cmd = c; req_addA = a; req_addB = b; req_addC = cc; req_data = d;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
      if (!ok && rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    req_valid = 1'b0;
    chk("push_accepted", 64'(ok), 64'd1);
    if (ok) model_push(c, a, b, cc, d);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_iss.size() != 0 || expq.size() != 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_drained"}, 64'(exp_iss.size() + expq.size()), 64'd0);
    chk({tag, "_issued_cnt"}, 64'(issued_cnt), 64'(pushed[15:0]));
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk(tag, 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] sd [5];
    logic [15:0] cnt0;
    int acc;
    logic ok;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_issued_cnt", 64'(issued_cnt), 64'd0);
    chk("rst_bus_idle", 64'({cmd, addA, addB, addC, DQ_i}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_no_issue", 64'({issued_cnt, cmd, addA, DQ_i}), 64'd0);
    @(posedge clk); #1;

    // Write then read back.
    rsp_hi = 0;
    push(WR, 8'h10, 8'h00, 8'h00, 16'hBEEF);
    push(RD, 8'h10, 8'h00, 8'h00, 16'h0000);
    wait_idle("wr_rd");
    chk("wr_rd_data", 64'(rsp_data), 64'hBEEF);
    chk("wr_rd_valid_cycles", 64'(rsp_hi), 64'd1);
    chk("wr_rd_issued", 64'(issued_cnt), 64'd2);

    // Read latency from an idle, empty queue.
    push(RD, 8'h10, 8'h00, 8'h00, 16'h0000);
    @(negedge clk);
    chk("lat_idle_cycle_k", 64'(addA), 64'd0);
    @(negedge clk);
    chk("lat_issue_cycle", 64'({cmd, addA}), 64'({RD, 8'h10}));
    for (int t = 0; t < LAT; t++) begin
      @(negedge clk);
      chk("lat_rsp_early", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    wait_idle("lat");

    // Arithmetic with wrap-around.
    push(WR, 8'h01, 8'h00, 8'h00, 16'hFFFF);
    push(WR, 8'h02, 8'h00, 8'h00, 16'h0002);
    push(ADD, 8'h01, 8'h02, 8'h03, 16'h0000);
    push(RD, 8'h03, 8'h00, 8'h00, 16'h0000);
    wait_idle("add");
    chk("add_wrap_data", 64'(rsp_data), 64'h0001);
    push(SUB, 8'h02, 8'h01, 8'h04, 16'h0000);
    push(RD, 8'h04, 8'h00, 8'h00, 16'h0000);
    wait_idle("sub");
    chk("sub_wrap_data", 64'(rsp_data), 64'h0003);

    // Response backpressure: queue fills, nothing issues, held data stays put.
    rsp_ready = 1'b0;
    push(RD, 8'h10, 8'h00, 8'h00, 16'h0000);
    wait_rsp_valid("stall_rsp_reached");
    cnt0 = issued_cnt;
    for (int i = 0; i < 5; i++) sd[i] = 16'($urandom);
    acc = 0;
    for (int t = 0; t < 10; t++) begin
      req_valid = (acc < 5);
      req_cmd = WR; req_addA = 8'h40 + 8'(acc); req_addB = '0; req_addC = '0;
      req_data = sd[acc % 5];
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_data", 64'(rsp_data), 64'hBEEF);
      chk("stall_no_issue", 64'(issued_cnt), 64'(cnt0));
      ok = req_ready && req_valid;
      @(posedge clk); #1;
      if (ok) begin
        model_push(WR, 8'h40 + 8'(acc), 8'h00, 8'h00, sd[acc]);
        acc++;
      end
    end
    req_valid = 1'b0;
    chk("stall_accepted", 64'(acc), 64'd4);
    chk("stall_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    push(WR, 8'h44, 8'h00, 8'h00, sd[4]);
    wait_idle("stall");

    // Back-to-back writes issue on consecutive cycles.
    iss_cyc.delete();
    for (int i = 0; i < 4; i++) push(WR, 8'h30 + 8'(i), 8'h00, 8'h00, 16'($urandom));
    wait_idle("b2b");
    chk("b2b_issue_count", 64'(iss_cyc.size()), 64'd4);
    if (iss_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_consecutive", 64'(iss_cyc[i] - iss_cyc[0]), 64'(i));
    end
    @(negedge clk);
    chk("b2b_idle_after", 64'({cmd, addA, addB, addC, DQ_i}), 64'd0);
    @(posedge clk); #1;

    // Reset while waiting on a read with three commands queued.
    rsp_ready = 1'b0;
    push(RD, 8'h10, 8'h00, 8'h00, 16'h0000);
    wait_rsp_valid("rst_mid_rsp");
    for (int i = 0; i < 4; i++) push(RD, 8'h10, 8'h00, 8'h00, 16'h0000);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_pre_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    #1;
    exp_iss.delete();
    expq.delete();
    pushed = 0;
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_issued", 64'(issued_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("rst_mid_quiet", 64'({issued_cnt, rsp_valid, cmd, addA, DQ_i}), 64'd0);
    end
    @(posedge clk); #1;

    // Counter wrap after 65535 writes plus one.
    for (int i = 0; i < 65535; i++) push(WR, 8'h50, 8'h00, 8'h00, 16'(i));
    wait_idle("cnt_full");
    chk("cnt_ffff", 64'(issued_cnt), 64'hFFFF);
    push(WR, 8'h50, 8'h00, 8'h00, 16'h1234);
    wait_idle("cnt_wrap");
    chk("cnt_wrap_zero", 64'(issued_cnt), 64'h0000);

    // Randomized mix against the reference model.
    for (int i = 0; i < 8; i++) push(WR, 8'h20 + 8'(i), 8'h00, 8'h00, 16'($urandom));
    rnd_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      push(2'($urandom_range(0, 3)), 8'h20 + 8'($urandom_range(0, 7)),
           8'h20 + 8'($urandom_range(0, 7)), 8'h20 + 8'($urandom_range(0, 7)), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_ready = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
